// File: rtl/nts_verify_sequencer.sv
// Command sequencer for the NTS AES-SIV verify engine: copies AD, nonce and tag from the RX buffer, then runs verify.
// Optional per-op watchdog enabled by defining NTS_VERIFY_SEQUENCER_TIMEOUT_EN.
module nts_verify_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                  i_areset,
    input  logic                  i_clk,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH+2:0] i_ad_addr,
    input  logic [9:0]            i_ad_bytes,
    input  logic [ADDR_WIDTH+2:0] i_nonce_addr,
    input  logic [ADDR_WIDTH+2:0] i_tag_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_verify_ok,
    output logic                  o_error,
    output logic                  o_op_copy_rx_ad,
    output logic                  o_op_copy_rx_nonce,
    output logic                  o_op_copy_rx_tag,
    output logic                  o_op_verify,
    output logic [ADDR_WIDTH+2:0] o_copy_rx_addr,
    output logic [9:0]            o_copy_rx_bytes,
    input  logic                  i_vs_busy,
    input  logic                  i_vs_tag_ok
);

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        ISSUE_AD,
        WAIT_AD,
        ISSUE_NONCE,
        WAIT_NONCE,
        ISSUE_TAG,
        WAIT_TAG,
        ISSUE_VERIFY,
        WAIT_VERIFY,
        FINISH
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH+2:0] adAddr_q;
    logic [9:0]            adBytes_q;
    logic [ADDR_WIDTH+2:0] nonceAddr_q;
    logic [ADDR_WIDTH+2:0] tagAddr_q;
    logic                  opAd_q;
    logic                  opNonce_q;
    logic                  opTag_q;
    logic                  opVerify_q;
    logic [ADDR_WIDTH+2:0] copyAddr_q;
    logic [9:0]            copyBytes_q;
    logic                  done_q;
    logic                  verifyOk_q;
    logic                  error_q;

    logic paramBad;
    logic opPending;
    logic timeoutHit;

    if (TIMEOUT_BITS < 2) begin : gBadTimeoutBits
        $error("TIMEOUT_BITS must be at least 2");
    end

    assign paramBad = (adBytes_q == 10'd0) || (adBytes_q[2:0] != 3'd0) ||
                      (adAddr_q[2:0] != 3'd0) || (nonceAddr_q[2:0] != 3'd0) ||
                      (tagAddr_q[2:0] != 3'd0);

    // The op register is high exactly in the first WAIT cycle, before the engine can have raised busy.
    assign opPending = opAd_q | opNonce_q | opTag_q | opVerify_q;

`ifdef NTS_VERIFY_SEQUENCER_TIMEOUT_EN
    state_t                  prevState_q;
    logic [TIMEOUT_BITS-1:0] timer_q;
    logic [TIMEOUT_BITS-1:0] timerNow;
    logic                    inOpState;

    assign inOpState  = (state_q inside {ISSUE_AD, WAIT_AD, ISSUE_NONCE, WAIT_NONCE,
                                         ISSUE_TAG, WAIT_TAG, ISSUE_VERIFY, WAIT_VERIFY});
    assign timerNow   = (state_q != prevState_q) ? '0 : timer_q;
    assign timeoutHit = inOpState && (timerNow == '1);

    // Watchdog restarts from zero on every state change, so each ISSUE/WAIT state gets its own budget.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            prevState_q <= IDLE;
            timer_q     <= '0;
        end else begin
            prevState_q <= state_q;
            timer_q     <= timerNow + 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q     <= IDLE;
            adAddr_q    <= '0;
            adBytes_q   <= '0;
            nonceAddr_q <= '0;
            tagAddr_q   <= '0;
            opAd_q      <= 1'b0;
            opNonce_q   <= 1'b0;
            opTag_q     <= 1'b0;
            opVerify_q  <= 1'b0;
            copyAddr_q  <= '0;
            copyBytes_q <= '0;
            done_q      <= 1'b0;
            verifyOk_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            opAd_q      <= 1'b0;
            opNonce_q   <= 1'b0;
            opTag_q     <= 1'b0;
            opVerify_q  <= 1'b0;
            copyAddr_q  <= '0;
            copyBytes_q <= '0;
            done_q      <= 1'b0;

            if ((state_q != IDLE) && i_abort) begin
                state_q <= IDLE;
            end else if (timeoutHit) begin
                error_q    <= 1'b1;
                verifyOk_q <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= FINISH;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            adAddr_q    <= i_ad_addr;
                            adBytes_q   <= i_ad_bytes;
                            nonceAddr_q <= i_nonce_addr;
                            tagAddr_q   <= i_tag_addr;
                            verifyOk_q  <= 1'b0;
                            error_q     <= 1'b0;
                            state_q     <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (paramBad) begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            state_q <= ISSUE_AD;
                        end
                    end
                    ISSUE_AD: begin
                        if (!i_vs_busy) begin
                            opAd_q      <= 1'b1;
                            copyAddr_q  <= adAddr_q;
                            copyBytes_q <= adBytes_q;
                            state_q     <= WAIT_AD;
                        end
                    end
                    WAIT_AD: begin
                        if (!opPending && !i_vs_busy) state_q <= ISSUE_NONCE;
                    end
                    ISSUE_NONCE: begin
                        if (!i_vs_busy) begin
                            opNonce_q   <= 1'b1;
                            copyAddr_q  <= nonceAddr_q;
                            copyBytes_q <= 10'd16;
                            state_q     <= WAIT_NONCE;
                        end
                    end
                    WAIT_NONCE: begin
                        if (!opPending && !i_vs_busy) state_q <= ISSUE_TAG;
                    end
                    ISSUE_TAG: begin
                        if (!i_vs_busy) begin
                            opTag_q     <= 1'b1;
                            copyAddr_q  <= tagAddr_q;
                            copyBytes_q <= 10'd16;
                            state_q     <= WAIT_TAG;
                        end
                    end
                    WAIT_TAG: begin
                        if (!opPending && !i_vs_busy) state_q <= ISSUE_VERIFY;
                    end
                    ISSUE_VERIFY: begin
                        if (!i_vs_busy) begin
                            opVerify_q <= 1'b1;
                            state_q    <= WAIT_VERIFY;
                        end
                    end
                    WAIT_VERIFY: begin
                        if (!opPending && !i_vs_busy) begin
                            verifyOk_q <= i_vs_tag_ok;
                            done_q     <= 1'b1;
                            state_q    <= FINISH;
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy             = (state_q != IDLE);
    assign o_done             = done_q;
    assign o_verify_ok        = verifyOk_q;
    assign o_error            = error_q;
    assign o_op_copy_rx_ad    = opAd_q;
    assign o_op_copy_rx_nonce = opNonce_q;
    assign o_op_copy_rx_tag   = opTag_q;
    assign o_op_verify        = opVerify_q;
    assign o_copy_rx_addr     = copyAddr_q;
    assign o_copy_rx_bytes    = copyBytes_q;

endmodule

// File: tb/tb_nts_verify_sequencer.sv
// Directed self-checking bench for nts_verify_sequencer with a simple busy-for-N-cycles engine model.
module tb_nts_verify_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abortCmd;
    logic [10:0] adAddr;
    logic [9:0]  adBytes;
    logic [10:0] nonceAddr;
    logic [10:0] tagAddr;
    logic        busyOut;
    logic        doneOut;
    logic        verifyOk;
    logic        errorOut;
    logic        opAd;
    logic        opNonce;
    logic        opTag;
    logic        opVerify;
    logic [10:0] copyAddr;
    logic [9:0]  copyBytes;
    logic        vsBusy;
    logic        tagOk;

    logic        forceBusy;
    logic        engBusy;
    int          engCnt;
    int          busyLen;

    int          total;
    int          bad;

    int          opCount;
    int          doneCount;
    int          copyLeak;
    int          multiOp;
    int          opKind  [64];
    int          opAddr  [64];
    int          opBytes [64];

    nts_verify_sequencer #(
        .ADDR_WIDTH(8),
        .TIMEOUT_BITS(16)
    ) dut (
        .i_areset          (reset),
        .i_clk             (clk),
        .i_start           (start),
        .i_abort           (abortCmd),
        .i_ad_addr         (adAddr),
        .i_ad_bytes        (adBytes),
        .i_nonce_addr      (nonceAddr),
        .i_tag_addr        (tagAddr),
        .o_busy            (busyOut),
        .o_done            (doneOut),
        .o_verify_ok       (verifyOk),
        .o_error           (errorOut),
        .o_op_copy_rx_ad   (opAd),
        .o_op_copy_rx_nonce(opNonce),
        .o_op_copy_rx_tag  (opTag),
        .o_op_verify       (opVerify),
        .o_copy_rx_addr    (copyAddr),
        .o_copy_rx_bytes   (copyBytes),
        .i_vs_busy         (vsBusy),
        .i_vs_tag_ok       (tagOk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign vsBusy = engBusy | forceBusy;

    // Engine model: busy for busyLen cycles after seeing any op pulse.
    initial begin
        engCnt  = 0;
        engBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (opAd | opNonce | opTag | opVerify) engCnt = busyLen;
            else if (engCnt > 0) engCnt = engCnt - 1;
            engBusy = (engCnt > 0);
        end
    end

    // Op logger: records every op pulse with the copy parameters shown alongside it.
    initial begin
        opCount   = 0;
        doneCount = 0;
        copyLeak  = 0;
        multiOp   = 0;
        forever begin
            @(negedge clk);
            if (opAd | opNonce | opTag | opVerify) begin
                if (opCount < 64) begin
                    opKind[opCount]  = opAd ? 0 : opNonce ? 1 : opTag ? 2 : 3;
                    opAddr[opCount]  = int'(copyAddr);
                    opBytes[opCount] = int'(copyBytes);
                end
                if ((int'(opAd) + int'(opNonce) + int'(opTag) + int'(opVerify)) > 1) multiOp++;
                opCount++;
            end
            if (!(opAd | opNonce | opTag) && ((copyAddr != 11'd0) || (copyBytes != 10'd0))) copyLeak++;
            if (doneOut) doneCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] ad, input logic [9:0] bytesIn,
                                 input logic [10:0] nonce, input logic [10:0] tagIn);
        @(negedge clk);
        adAddr    = ad;
        adBytes   = bytesIn;
        nonceAddr = nonce;
        tagAddr   = tagIn;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (doneOut) break;
        end
    endtask

    task automatic checkNominalOps(input string tag, input int base, input int ad, input int bytesIn,
                                   input int nonce, input int tagIn);
        checkOutput({tag, "_opcount"}, opCount - base, 4);
        for (int i = 0; i < 4; i++) checkOutput({tag, "_kind"}, opKind[base + i], i);
        checkOutput({tag, "_ad_addr"}, opAddr[base], ad);
        checkOutput({tag, "_ad_bytes"}, opBytes[base], bytesIn);
        checkOutput({tag, "_nonce_addr"}, opAddr[base + 1], nonce);
        checkOutput({tag, "_nonce_bytes"}, opBytes[base + 1], 16);
        checkOutput({tag, "_tag_addr"}, opAddr[base + 2], tagIn);
        checkOutput({tag, "_tag_bytes"}, opBytes[base + 2], 16);
        checkOutput({tag, "_verify_addr"}, opAddr[base + 3], 0);
    endtask

    initial begin
        int cycles;
        int base;
        int doneBase;

        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        abortCmd  = 1'b0;
        adAddr    = '0;
        adBytes   = '0;
        nonceAddr = '0;
        tagAddr   = '0;
        tagOk     = 1'b0;
        forceBusy = 1'b0;
        busyLen   = 3;

        #1;
        checkOutput("reset_busy", busyOut, 0);
        checkOutput("reset_done", doneOut, 0);
        checkOutput("reset_ops", {opAd, opNonce, opTag, opVerify}, 0);
        checkOutput("reset_flags", {verifyOk, errorOut}, 0);
        checkOutput("reset_copy", {copyAddr, copyBytes}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Nominal command: 5 cycles per op with a 3-cycle engine, done 21 cycles after CHECK.
        tagOk = 1'b1;
        base  = opCount;
        applyStimulus(11'h020, 10'd32, 11'h040, 11'h050);
        checkOutput("nom_busy_check", busyOut, 1);
        waitDone(60, cycles);
        checkOutput("nom_latency", cycles, 21);
        checkOutput("nom_verify_ok", verifyOk, 1);
        checkOutput("nom_error", errorOut, 0);
        checkNominalOps("nom", base, 'h020, 32, 'h040, 'h050);
        @(negedge clk);
        checkOutput("nom_done_once", doneOut, 0);
        checkOutput("nom_idle", busyOut, 0);
        checkOutput("nom_ok_hold", verifyOk, 1);

        // Bad parameters: done one cycle after CHECK, no ops, error set.
        base = opCount;
        applyStimulus(11'h020, 10'd12, 11'h040, 11'h050);
        waitDone(10, cycles);
        checkOutput("bad12_latency", cycles, 1);
        checkOutput("bad12_flags", {verifyOk, errorOut}, 2'b01);
        applyStimulus(11'h020, 10'd0, 11'h040, 11'h050);
        waitDone(10, cycles);
        checkOutput("bad0_latency", cycles, 1);
        checkOutput("bad0_error", errorOut, 1);
        applyStimulus(11'h020, 10'd32, 11'h040, 11'h053);
        waitDone(10, cycles);
        checkOutput("badtag_latency", cycles, 1);
        checkOutput("badtag_error", errorOut, 1);
        checkOutput("bad_no_ops", opCount - base, 0);

        // Engine busy at start: AD op waits for busy to drop.
        base      = opCount;
        forceBusy = 1'b1;
        applyStimulus(11'h008, 10'd8, 11'h100, 11'h200);
        checkOutput("bz_error_cleared", errorOut, 0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        checkOutput("bz_no_op", opCount - base, 0);
        checkOutput("bz_held", busyOut, 1);
        forceBusy = 1'b0;
        @(negedge clk);
        checkOutput("bz_ad_pulse", opAd, 1);
        checkOutput("bz_ad_addr", copyAddr, 11'h008);
        waitDone(60, cycles);
        checkOutput("bz_done", doneOut, 1);
        checkOutput("bz_error", errorOut, 0);
        checkNominalOps("bz", base, 'h008, 8, 'h100, 'h200);

        // Abort in WAIT_NONCE together with a start strobe.
        base     = opCount;
        doneBase = doneCount;
        applyStimulus(11'h020, 10'd32, 11'h040, 11'h050);
        repeat (8) @(negedge clk);
        abortCmd = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        abortCmd = 1'b0;
        start    = 1'b0;
        checkOutput("ab_idle", busyOut, 0);
        checkOutput("ab_no_done", doneOut, 0);
        repeat (20) @(negedge clk);
        checkOutput("ab_ops", opCount - base, 2);
        checkOutput("ab_done_count", doneCount - doneBase, 0);
        checkOutput("ab_still_idle", busyOut, 0);

        // Fresh command after abort with a failing tag.
        tagOk = 1'b0;
        base  = opCount;
        applyStimulus(11'h018, 10'd16, 11'h060, 11'h070);
        waitDone(60, cycles);
        checkOutput("fr_latency", cycles, 21);
        checkOutput("fr_flags", {verifyOk, errorOut}, 2'b00);
        checkNominalOps("fr", base, 'h018, 16, 'h060, 'h070);

        // Reset asserted while in ISSUE_VERIFY.
        tagOk = 1'b1;
        applyStimulus(11'h020, 10'd32, 11'h040, 11'h050);
        repeat (16) @(negedge clk);
        checkOutput("rs_in_issue", {busyOut, opAd, opNonce, opTag, opVerify}, 5'b10000);
        reset = 1'b1;
        #1;
        checkOutput("rs_busy", busyOut, 0);
        checkOutput("rs_ops", {opAd, opNonce, opTag, opVerify, doneOut}, 0);
        checkOutput("rs_flags", {verifyOk, errorOut}, 0);
        @(negedge clk);
        reset = 1'b0;
        base  = opCount;
        applyStimulus(11'h020, 10'd32, 11'h040, 11'h050);
        checkOutput("rs_accept", busyOut, 1);
        waitDone(60, cycles);
        checkOutput("rs_latency", cycles, 21);
        checkOutput("rs_verify_ok", verifyOk, 1);
        checkNominalOps("rs", base, 'h020, 32, 'h040, 'h050);

        @(negedge clk);
        checkOutput("copy_zero_outside_ops", copyLeak, 0);
        checkOutput("single_op_per_cycle", multiOp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nts_verify_sequencer.md
Name: nts_verify_sequencer

Overview:
Command-level controller for the NTS verify/secure datapath (AES-SIV verify engine with RX-buffer copier). It accepts one "verify packet" command containing the AD, nonce and tag locations. It then issues the four single-cycle ops (copy AD, copy nonce, copy tag, verify) strictly in order, waiting for the engine's busy to drop between ops. When the sequence finishes it reports done, verify result and error.

Parameters:
ADDR_WIDTH, 8, RX buffer address width in 64-bit words; byte addresses are ADDR_WIDTH+3 bits.
TIMEOUT_BITS, 16, width of per-op watchdog counter (used only with the optional feature).

Ports:
i_areset  in  1  async reset, active-high
i_clk  in  1  clock
i_start  in  1  command strobe; ignored unless in IDLE
i_abort  in  1  abandon current command
i_ad_addr  in  ADDR_WIDTH+3  AD byte address in RX buffer
i_ad_bytes  in  10  AD length in bytes
i_nonce_addr  in  ADDR_WIDTH+3  nonce byte address
i_tag_addr  in  ADDR_WIDTH+3  tag byte address
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle completion pulse
o_verify_ok  out  1  tag comparison result of last command
o_error  out  1  last command failed (parameter or timeout)
o_op_copy_rx_ad  out  1  op pulse to engine
o_op_copy_rx_nonce  out  1  op pulse to engine
o_op_copy_rx_tag  out  1  op pulse to engine
o_op_verify  out  1  op pulse to engine
o_copy_rx_addr  out  ADDR_WIDTH+3  copy start address, valid with the copy op pulse
o_copy_rx_bytes  out  10  copy length, valid with the copy op pulse
i_vs_busy  in  1  engine busy
i_vs_tag_ok  in  1  engine tag_ok, valid when engine returns idle after verify

Behaviour:
- Reset: i_areset, asynchronous, active-high; clock i_clk. All outputs 0, state IDLE, latched command registers 0.
- Outputs: o_op_*, o_copy_rx_addr and o_copy_rx_bytes are driven from registers, so there is no combinational path from engine inputs to ops. o_copy_rx_* are 0 except in cycles where a copy op pulses.
- States: IDLE, CHECK, ISSUE_AD, WAIT_AD, ISSUE_NONCE, WAIT_NONCE, ISSUE_TAG, WAIT_TAG, ISSUE_VERIFY, WAIT_VERIFY, FINISH.
- IDLE: on i_start, latch all command inputs, clear o_verify_ok and o_error, and go to CHECK.
- CHECK (1 cycle) fails on any of:
  - i_ad_bytes == 0;
  - i_ad_bytes[2:0] != 0;
  - any address with bits [2:0] != 0.
  On failure, set o_error=1 and go to FINISH; no op is issued. Otherwise go to ISSUE_AD.
- ISSUE_x: wait while i_vs_busy=1. When i_vs_busy=0, pulse exactly one op for one cycle and go to WAIT_x. Copy parameters per op:
  - AD: latched AD address and bytes;
  - nonce: nonce address, 16 bytes;
  - tag: tag address, 16 bytes.
- WAIT_x: the first cycle is unconditional, because engine busy rises one cycle after the op. After that, exit when i_vs_busy=0:
  - WAIT_AD goes to ISSUE_NONCE;
  - WAIT_NONCE goes to ISSUE_TAG;
  - WAIT_TAG goes to ISSUE_VERIFY;
  - WAIT_VERIFY samples i_vs_tag_ok into o_verify_ok, then goes to FINISH.
- FINISH: o_done=1 for exactly one cycle, then IDLE. o_verify_ok and o_error hold until the next accepted i_start.
- Minimum latency with engine busy for 1 cycle per op: start to done = 1 (CHECK) + 4×3 + 1 = 14 cycles.
- i_abort in any non-IDLE state: go to IDLE at the next edge with no o_done, and no op pulse in that cycle. An engine op already pulsed is not cancelled. i_abort takes priority over every other transition, including i_start in the same cycle; i_abort in IDLE has no effect.
- i_start while busy is ignored and not queued.
- Byte address arithmetic is ADDR_WIDTH+3 bits. The sequencer does not check wrap of addr+bytes; the engine owns range handling.

Optional Feature:
NTS_VERIFY_SEQUENCER_TIMEOUT_EN:
- With the macro: a TIMEOUT_BITS counter clears on entry to each ISSUE_x and WAIT_x state and increments every cycle there. Reaching all-ones sets o_error=1 and goes to FINISH (o_done pulses, o_verify_ok=0).
- Without the macro: the counter is absent and the sequencer waits indefinitely.

Test Plan:
- Nominal: AD 0x020 / 32 bytes, nonce 0x040, tag 0x050, engine busy 3 cycles per op, tag_ok=1 -> ops in order AD(0x020, 32), nonce(0x040, 16), tag(0x050, 16), verify; one o_done pulse; o_verify_ok=1, o_error=0.
- Bad parameters: i_ad_bytes=12, then i_ad_bytes=0, then i_tag_addr=0x053 -> no op pulses; o_done 2 cycles after start; o_error=1.
- Engine busy at start: i_vs_busy held high 5 cycles after start -> no o_op_copy_rx_ad pulse until the cycle i_vs_busy=0; sequence then completes.
- Abort in WAIT_NONCE, with i_start in the same cycle -> IDLE next cycle; no o_done and no further ops. A fresh start afterwards completes normally with tag_ok=0, giving o_verify_ok=0.
- Timeout (macro on, TIMEOUT_BITS=4): engine busy stuck high after the tag op -> o_done with o_error=1 15 cycles after entering WAIT_TAG; no verify op is issued.
- Reset mid-sequence, asserted in ISSUE_VERIFY -> all outputs 0 immediately; after reset release, i_start is accepted.
